// File: rtl/cnt_sched_pkg.sv
// Shared types and constants for the burst scheduler.
// FSM encoding, requester count, counter channel ids.
package cnt_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  localparam int NREQ = 2;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

endpackage

// File: rtl/cnt_sched_if.sv
// Requester/counter-side bundle of the burst scheduler.
// master: requesting logic; slave: cnt_sched.
interface cnt_sched_if #(
  parameter int LEN_W = 4
);
  import cnt_sched_pkg::*;

  logic [NREQ-1:0]  req_valid;
  logic [NREQ-1:0]  req_chan;
  logic [LEN_W-1:0] req_len0;
  logic [LEN_W-1:0] req_len1;
  logic             Hold;
  logic [NREQ-1:0]  req_ready;
  logic [NREQ-1:0]  done;
  logic             Slt;
  logic             En;
  logic             busy;

  modport master (
    output req_valid, req_chan,
    output req_len0, req_len1, Hold,
    input  req_ready, done,
    input  Slt, En, busy
  );

  modport slave (
    input  req_valid, req_chan,
    input  req_len0, req_len1, Hold,
    output req_ready, done,
    output Slt, En, busy
  );

endinterface

// File: rtl/cnt_sched_arb.sv
// rr_arb2: combinational 2-way round-robin arbiter.
// req: requests, last: last served id, gnt: one-hot grant.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req[0] & req[1]):
        gnt = last ? 2'b01 : 2'b10;
      (req[0] & ~req[1]):
        gnt = 2'b01;
      (~req[0] & req[1]):
        gnt = 2'b10;
      default:
        gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/cnt_sched.sv
// Burst scheduler driving Slt/En of the 2-channel counter.
// Ports: Clk, Reset (sync, high), bus (cnt_sched_if.slave).
module cnt_sched
  import cnt_sched_pkg::*;
#(
  parameter int LEN_W = 4
) (
  input logic       Clk,
  input logic       Reset,
  cnt_sched_if.slave bus
);

  state_t           st;
  state_t           st_nx;
  logic             cur_req;
  logic             cur_chan;
  logic             last_srv;
  logic [LEN_W-1:0] rem;
  logic [NREQ-1:0]  gnt;
  logic [NREQ-1:0]  done_q;
  logic             win;
  logic             win_chan;
  logic [LEN_W-1:0] win_len;
  logic             accept;
  logic             en_i;

  rr_arb2 u_arb (
    .req  (bus.req_valid),
    .last (last_srv),
    .gnt  (gnt)
  );

  assign win      = gnt[1];
  assign win_chan = bus.req_chan[win];
  assign win_len  = win ? bus.req_len1
                        : bus.req_len0;

  assign accept = (st == IDLE) && (|gnt)
                && !Reset;
  assign en_i   = (st == ISSUE) && !bus.Hold
                && !Reset;

  always_comb begin
    st_nx = st;
    unique case (st)
      IDLE:
        if (accept && (win_len != '0))
          st_nx = ISSUE;
      ISSUE:
        if (en_i && (rem == LEN_W'(1)))
          st_nx = IDLE;
      default:
        st_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      st       <= IDLE;
      rem      <= '0;
      cur_req  <= 1'b0;
      cur_chan <= CH0;
      last_srv <= 1'b1;
      done_q   <= '0;
    end else begin
      st     <= st_nx;
      done_q <= '0;
      if (accept) begin
        cur_req  <= win;
        cur_chan <= win_chan;
        rem      <= win_len;
        last_srv <= win;
        // zero-length burst completes without issuing
        if (win_len == '0)
          done_q <= gnt;
      end else if (en_i) begin
        rem <= rem - LEN_W'(1);
        if (rem == LEN_W'(1))
          done_q <= cur_req ? 2'b10 : 2'b01;
      end
    end
  end

  assign bus.req_ready = accept ? gnt : '0;
  assign bus.En        = en_i;
  assign bus.Slt       = ((st == ISSUE) && !Reset)
                       ? cur_chan : CH0;
  assign bus.busy      = (st == ISSUE);
  assign bus.done      = done_q;

endmodule

// File: tb/tb_cnt_sched.sv
// Self-checking bench for cnt_sched with a burst scoreboard
// and a model of the downstream 2-channel counter.
module tb_cnt_sched;
  import cnt_sched_pkg::*;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  cnt_sched_if #(.LEN_W(4)) bus ();

  cnt_sched #(.LEN_W(4)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] oh;
    logic       chan;
    int         len;
  } exp_t;

  exp_t exp_q[$];
  int en_cnt = 0;
  int out0 = 0;
  int out1 = 0;
  int presc = 0;

  // scoreboard + counter model
  always @(negedge Clk) begin
    if (Reset) begin
      exp_q.delete();
      en_cnt = 0;
      out0 = 0;
      out1 = 0;
      presc = 0;
    end else begin
      if (bus.En) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_en: En=1 want no burst");
        end else if (bus.Slt !== exp_q[0].chan) begin
          bad++;
          $display("FAIL sb_slt: got %b want %b",
                   bus.Slt, exp_q[0].chan);
        end
        en_cnt++;
        if (bus.Slt) begin
          if (presc == 3) begin
            presc = 0;
            out1++;
          end else presc++;
        end else out0++;
      end
      if (bus.done !== 2'b00) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_done: got %b want none",
                   bus.done);
        end else begin
          if (bus.done !== exp_q[0].oh ||
              en_cnt != exp_q[0].len) begin
            bad++;
            $display("FAIL sb_burst: done=%b n=%0d want %b n=%0d",
                     bus.done, en_cnt,
                     exp_q[0].oh, exp_q[0].len);
          end
          void'(exp_q.pop_front());
        end
        en_cnt = 0;
      end
    end
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = 2'b00;
    bus.req_chan  = 2'b00;
    bus.req_len0  = 4'd0;
    bus.req_len1  = 4'd0;
    bus.Hold      = 1'b0;
  endtask

  task automatic do_reset();
    step();
    Reset = 1'b1;
    idle_inputs();
    step();
    step();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    idle_inputs();
    bus.req_valid = 2'b11;
    bus.req_len0  = 4'd3;
    bus.req_len1  = 4'd3;
    @(negedge Clk);
    total++;
    if ({bus.req_ready, bus.done, bus.busy,
         bus.En, bus.Slt} !== 7'b0) begin
      bad++;
      $display("FAIL rst_outs: rdy=%b done=%b busy=%b En=%b Slt=%b want 0",
               bus.req_ready, bus.done, bus.busy,
               bus.En, bus.Slt);
    end
    step();
    idle_inputs();
    @(negedge Clk);
    total++;
    if ({bus.req_ready, bus.done, bus.busy,
         bus.En, bus.Slt} !== 7'b0) begin
      bad++;
      $display("FAIL rst_state: rdy=%b done=%b busy=%b En=%b want 0",
               bus.req_ready, bus.done, bus.busy, bus.En);
    end
    Reset = 1'b0;
  endtask

  task automatic test_single();
    exp_t e;
    do_reset();
    bus.req_valid = 2'b01;
    bus.req_len0  = 4'd3;
    @(negedge Clk);
    total++;
    if (bus.req_ready !== 2'b01) begin
      bad++;
      $display("FAIL single_rdy: got %b want 01",
               bus.req_ready);
    end
    e.oh = 2'b01; e.chan = 1'b0; e.len = 3;
    exp_q.push_back(e);
    for (int c = 1; c <= 4; c++) begin
      step();
      bus.req_valid = 2'b00;
      @(negedge Clk);
      total++;
      if (c <= 3) begin
        if (bus.En !== 1'b1 || bus.Slt !== 1'b0) begin
          bad++;
          $display("FAIL single_en c%0d: En=%b Slt=%b want 1 0",
                   c, bus.En, bus.Slt);
        end
      end else if (bus.En !== 1'b0 ||
                   bus.done !== 2'b01) begin
        bad++;
        $display("FAIL single_done: En=%b done=%b want 0 01",
                 bus.En, bus.done);
      end
    end
    total++;
    if (out0 != 3) begin
      bad++;
      $display("FAIL single_out0: got %0d want 3", out0);
    end
  endtask

  task automatic test_rr();
    exp_t e;
    logic [1:0] want;
    int g = 0;
    do_reset();
    bus.req_valid = 2'b11;
    bus.req_chan  = 2'b10;
    bus.req_len0  = 4'd2;
    bus.req_len1  = 4'd4;
    for (int c = 0; c < 40 && g < 4; c++) begin
      @(negedge Clk);
      if (bus.req_ready !== 2'b00) begin
        want = (g % 2 == 0) ? 2'b01 : 2'b10;
        total++;
        if (bus.req_ready !== want) begin
          bad++;
          $display("FAIL rr_grant%0d: got %b want %b",
                   g, bus.req_ready, want);
        end
        e.oh = want;
        e.chan = want[1];
        e.len = want[1] ? 4 : 2;
        exp_q.push_back(e);
        g++;
      end
      step();
    end
    bus.req_valid = 2'b00;
    total++;
    if (g != 4) begin
      bad++;
      $display("FAIL rr_timeout: grants=%0d want 4", g);
    end
    for (int c = 0; c < 30 && exp_q.size() != 0; c++)
      @(negedge Clk);
    @(negedge Clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL rr_drain: left=%0d want 0",
               exp_q.size());
    end
    total++;
    if (out0 != 4 || out1 != 2) begin
      bad++;
      $display("FAIL rr_outs: o0=%0d o1=%0d want 4 2",
               out0, out1);
    end
  endtask

  task automatic test_zero();
    exp_t e;
    step();
    bus.req_valid = 2'b10;
    bus.req_chan  = 2'b00;
    bus.req_len1  = 4'd0;
    @(negedge Clk);
    total++;
    if (bus.req_ready !== 2'b10 || bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL zero_rdy: rdy=%b busy=%b want 10 0",
               bus.req_ready, bus.busy);
    end
    e.oh = 2'b10; e.chan = 1'b0; e.len = 0;
    exp_q.push_back(e);
    for (int c = 1; c <= 2; c++) begin
      step();
      bus.req_valid = 2'b00;
      @(negedge Clk);
      total++;
      if (bus.En !== 1'b0 || bus.busy !== 1'b0 ||
          bus.done !== ((c == 1) ? 2'b10 : 2'b00)) begin
        bad++;
        $display("FAIL zero_c%0d: En=%b busy=%b done=%b",
                 c, bus.En, bus.busy, bus.done);
      end
    end
  endtask

  task automatic test_hold();
    exp_t e;
    logic want_en;
    logic [1:0] want_done;
    step();
    bus.req_valid = 2'b01;
    bus.req_chan  = 2'b00;
    bus.req_len0  = 4'd5;
    @(negedge Clk);
    total++;
    if (bus.req_ready !== 2'b01) begin
      bad++;
      $display("FAIL hold_rdy: got %b want 01",
               bus.req_ready);
    end
    e.oh = 2'b01; e.chan = 1'b0; e.len = 5;
    exp_q.push_back(e);
    for (int c = 1; c <= 10; c++) begin
      step();
      bus.req_valid = 2'b00;
      bus.Hold = (c >= 3 && c <= 5);
      @(negedge Clk);
      want_en = (c <= 2) || (c >= 6 && c <= 8);
      want_done = (c == 9) ? 2'b01 : 2'b00;
      total++;
      if (bus.En !== want_en ||
          bus.done !== want_done) begin
        bad++;
        $display("FAIL hold_c%0d: En=%b done=%b want %b %b",
                 c, bus.En, bus.done, want_en, want_done);
      end
    end
    bus.Hold = 1'b0;
  endtask

  task automatic test_abort();
    exp_t e;
    step();
    bus.req_valid = 2'b01;
    bus.req_chan  = 2'b00;
    bus.req_len0  = 4'd15;
    @(negedge Clk);
    e.oh = 2'b01; e.chan = 1'b0; e.len = 15;
    exp_q.push_back(e);
    for (int c = 1; c <= 9; c++) begin
      step();
      bus.req_valid = 2'b00;
      Reset = (c == 6);
      if (c == 7) begin
        bus.req_valid = 2'b10;
        bus.req_chan  = 2'b10;
        bus.req_len1  = 4'd1;
      end
      @(negedge Clk);
      total++;
      if (c <= 5) begin
        if (bus.En !== 1'b1) begin
          bad++;
          $display("FAIL abort_en c%0d: got %b want 1",
                   c, bus.En);
        end
      end else if (c == 6) begin
        if (bus.En !== 1'b0 || bus.done !== 2'b00) begin
          bad++;
          $display("FAIL abort_rst: En=%b done=%b want 0 00",
                   bus.En, bus.done);
        end
      end else if (c == 7) begin
        if (bus.req_ready !== 2'b10 ||
            bus.En !== 1'b0 || bus.done !== 2'b00) begin
          bad++;
          $display("FAIL abort_next: rdy=%b En=%b done=%b",
                   bus.req_ready, bus.En, bus.done);
        end
        e.oh = 2'b10; e.chan = 1'b1; e.len = 1;
        exp_q.push_back(e);
      end else if (c == 8) begin
        if (bus.En !== 1'b1 || bus.Slt !== 1'b1 ||
            bus.done !== 2'b00) begin
          bad++;
          $display("FAIL abort_b2: En=%b Slt=%b done=%b",
                   bus.En, bus.Slt, bus.done);
        end
      end else if (bus.done !== 2'b10) begin
        bad++;
        $display("FAIL abort_done: got %b want 10",
                 bus.done);
      end
    end
  endtask

  task automatic test_max();
    exp_t e;
    do_reset();
    bus.req_valid = 2'b10;
    bus.req_chan  = 2'b10;
    bus.req_len1  = 4'd15;
    @(negedge Clk);
    total++;
    if (bus.req_ready !== 2'b10) begin
      bad++;
      $display("FAIL max_rdy: got %b want 10",
               bus.req_ready);
    end
    e.oh = 2'b10; e.chan = 1'b1; e.len = 15;
    exp_q.push_back(e);
    for (int c = 1; c <= 16; c++) begin
      step();
      bus.req_valid = 2'b00;
      @(negedge Clk);
      total++;
      if (c <= 15) begin
        if (bus.En !== 1'b1 || bus.Slt !== 1'b1) begin
          bad++;
          $display("FAIL max_en c%0d: En=%b Slt=%b want 1 1",
                   c, bus.En, bus.Slt);
        end
      end else if (bus.En !== 1'b0 ||
                   bus.done !== 2'b10) begin
        bad++;
        $display("FAIL max_done: En=%b done=%b want 0 10",
                 bus.En, bus.done);
      end
    end
    total++;
    if (out1 != 3 || presc != 3) begin
      bad++;
      $display("FAIL max_out1: o1=%0d pre=%0d want 3 3",
               out1, presc);
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single();
    test_rr();
    test_zero();
    test_hold();
    test_abort();
    test_max();
    repeat (3) @(negedge Clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_left: got %0d want 0",
               exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
